// File: rtl/uart_word_assembler.sv
// Packs received UART bytes into BYTES_PER_WORD-byte words in a selectable byte order,
// tags each word with a running byte address and hands it out through a one-entry valid/ready register.
module uart_word_assembler #(
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        io_data_valid,
  input  logic [7:0]                  io_data_packet,
  input  logic                        big_endian,
  input  logic                        restart,
  input  logic                        word_ready,
  output logic [8*BYTES_PER_WORD-1:0] instruction_word,
  output logic [ADDR_WIDTH-1:0]       byte_address,
  output logic                        word_valid,
  output logic                        timeout_err,
  output logic                        overrun
);
  localparam int W = 8 * BYTES_PER_WORD;
  localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(BYTES_PER_WORD);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  be_q, be_d;
  logic [W-1:0]          buf_q, buf_d;
  logic [TW-1:0]         idle_q, idle_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [W-1:0]          word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  tmo_q, tmo_d;
  logic                  overrun_q, overrun_d;

  logic                  accept;
  logic                  complete;
  logic                  expire;
  logic                  mode;
  logic [CW-1:0]         lane;
  logic [W-1:0]          base_word;
  logic [W-1:0]          asm_word;

  always_comb begin
    accept    = io_data_valid && !restart;
    complete  = accept && (count_q == LAST);
    mode      = (state_q == IDLE) ? big_endian : be_q;
    lane      = mode ? (LAST - count_q) : count_q;
    base_word = (state_q == IDLE) ? '0 : buf_q;
    expire    = TO_EN && (state_q == COLLECT) && !accept && !restart
                && ((idle_q + 1'b1) == TLIM);
  end

  // The incoming byte overwrites exactly one lane of the partial word.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    assign asm_word[8*gi +: 8] = (lane == CW'(gi)) ? io_data_packet : base_word[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      be_q        <= 1'b0;
      buf_q       <= '0;
      idle_q      <= '0;
      next_addr_q <= BASE_ADDR;
      word_q      <= '0;
      addr_q      <= BASE_ADDR;
      valid_q     <= 1'b0;
      tmo_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      be_q        <= be_d;
      buf_q       <= buf_d;
      idle_q      <= idle_d;
      next_addr_q <= next_addr_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      tmo_q       <= tmo_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    be_d    = be_q;
    buf_d   = buf_q;
    idle_d  = idle_q;
    if (restart || expire) begin
      state_d = IDLE;
      count_d = '0;
      idle_d  = '0;
    end else if (accept) begin
      idle_d = '0;
      if (complete) begin
        state_d = IDLE;
        count_d = '0;
      end else begin
        state_d = COLLECT;
        count_d = count_q + 1'b1;
        buf_d   = asm_word;
        if (state_q == IDLE) be_d = big_endian;
      end
    end else if (TO_EN && state_q == COLLECT) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_comb begin
    word_d      = word_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    next_addr_d = next_addr_q;
    overrun_d   = overrun_q;
    tmo_d       = 1'b0;
    if (restart) begin
      valid_d     = 1'b0;
      overrun_d   = 1'b0;
      next_addr_d = BASE_ADDR;
    end else begin
      // A consumer taking the held word in the same cycle frees the slot for the new one.
      if (complete) begin
        if (!valid_q || word_ready) begin
          word_d      = asm_word;
          addr_d      = next_addr_q;
          valid_d     = 1'b1;
          next_addr_d = next_addr_q + STRIDE;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (word_ready) begin
        valid_d = 1'b0;
      end
      tmo_d = expire;
    end
  end

  assign instruction_word = word_q;
  assign byte_address     = addr_q;
  assign word_valid       = valid_q;
  assign timeout_err      = tmo_q;
  assign overrun          = overrun_q;
endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed checks of three assembler configurations driven from one shared stimulus stream.
module tb_uart_word_assembler;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_valid = 1'b0;
  logic [7:0]  io_data = 8'h00;
  logic        big_endian = 1'b1;
  logic        restart = 1'b0;
  logic        word_ready = 1'b1;

  logic [31:0] a_word, a_addr, b_word, b_addr;
  logic        a_valid, a_tmo, a_ovr, b_valid, b_tmo, b_ovr;
  logic [15:0] c_word;
  logic [3:0]  c_addr;
  logic        c_valid, c_tmo, c_ovr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_word_assembler dut_a (
    .clk(clk), .reset_n(reset_n), .io_data_valid(io_valid), .io_data_packet(io_data),
    .big_endian(big_endian), .restart(restart), .word_ready(word_ready),
    .instruction_word(a_word), .byte_address(a_addr), .word_valid(a_valid),
    .timeout_err(a_tmo), .overrun(a_ovr)
  );

  uart_word_assembler #(.TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .io_data_valid(io_valid), .io_data_packet(io_data),
    .big_endian(big_endian), .restart(restart), .word_ready(word_ready),
    .instruction_word(b_word), .byte_address(b_addr), .word_valid(b_valid),
    .timeout_err(b_tmo), .overrun(b_ovr)
  );

  uart_word_assembler #(.BYTES_PER_WORD(2), .ADDR_WIDTH(4), .BASE_ADDR(4'hE)) dut_c (
    .clk(clk), .reset_n(reset_n), .io_data_valid(io_valid), .io_data_packet(io_data),
    .big_endian(big_endian), .restart(restart), .word_ready(word_ready),
    .instruction_word(c_word), .byte_address(c_addr), .word_valid(c_valid),
    .timeout_err(c_tmo), .overrun(c_ovr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    io_valid = 1'b1;
    io_data  = b;
    @(negedge clk);
    io_valid = 1'b0;
    $display("byte %h sent", b);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_a_word", a_word, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_tmo", a_tmo, 0);
    chk("rst_a_ovr", a_ovr, 0);
    chk("rst_c_addr", c_addr, 4'hE);

    // big-endian, consumer always ready
    send(8'h00); send(8'h40); send(8'h00); send(8'h93);
    chk("be1_valid", a_valid, 1);
    chk("be1_word", a_word, 32'h00400093);
    chk("be1_addr", a_addr, 32'h0);
    send(8'h00);
    chk("be1_valid_drop", a_valid, 0);
    send(8'h80); send(8'h01); send(8'h13);
    chk("be2_valid", a_valid, 1);
    chk("be2_word", a_word, 32'h00800113);
    chk("be2_addr", a_addr, 32'h4);
    @(negedge clk);
    chk("be2_valid_drop", a_valid, 0);
    chk("be2_ovr", a_ovr, 0);

    // little-endian with a mid-word mode toggle, after restart
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    big_endian = 1'b0;
    send(8'h00); send(8'h40);
    big_endian = 1'b1;
    send(8'h00); send(8'h93);
    chk("le_word", a_word, 32'h93004000);
    chk("le_addr", a_addr, 32'h0);
    chk("le_valid", a_valid, 1);

    // timeout on dut_b; dut_a has timeout disabled and keeps its partial word
    do_reset();
    send(8'h11); send(8'h22);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk($sformatf("tmo_b_cyc%0d", i), b_tmo, (i == 16) ? 1 : 0);
      chk($sformatf("tmo_a_cyc%0d", i), a_tmo, 0);
    end
    send(8'hAA); send(8'hBB);
    chk("tmo_a_word", a_word, 32'h1122AABB);
    chk("tmo_a_valid", a_valid, 1);
    send(8'hCC); send(8'hDD);
    chk("tmo_b_word", b_word, 32'hAABBCCDD);
    chk("tmo_b_addr", b_addr, 32'h0);
    chk("tmo_b_valid", b_valid, 1);

    // overrun with consumer stalled
    do_reset();
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("ovr_word", a_word, 32'h01020304);
    chk("ovr_addr", a_addr, 32'h0);
    chk("ovr_valid", a_valid, 1);
    chk("ovr_flag", a_ovr, 1);
    word_ready = 1'b1;
    @(negedge clk);
    chk("ovr_consumed", a_valid, 0);
    send(8'h09); send(8'h0A); send(8'h0B); send(8'h0C);
    chk("ovr_next_word", a_word, 32'h090A0B0C);
    chk("ovr_next_addr", a_addr, 32'h4);
    chk("ovr_sticky", a_ovr, 1);

    // restart colliding with a byte strobe
    send(8'h10); send(8'h20); send(8'h30);
    restart = 1'b1;
    send(8'h40);
    restart = 1'b0;
    chk("rs_valid", a_valid, 0);
    chk("rs_ovr", a_ovr, 0);
    send(8'h50); send(8'h60); send(8'h70); send(8'h80);
    chk("rs_word", a_word, 32'h50607080);
    chk("rs_addr", a_addr, 32'h0);

    // reset mid-word
    send(8'h01); send(8'h02);
    do_reset();
    chk("mrst_word", a_word, 0);
    chk("mrst_addr", a_addr, 0);
    chk("mrst_valid", a_valid, 0);
    chk("mrst_ovr", a_ovr, 0);
    send(8'h03); send(8'h04);
    chk("mrst_partial_valid", a_valid, 0);
    send(8'h05); send(8'h06);
    chk("mrst_word2", a_word, 32'h03040506);
    chk("mrst_addr2", a_addr, 32'h0);

    // two-byte words with a wrapping 4-bit address
    do_reset();
    send(8'h12); send(8'h34);
    chk("c_word1", c_word, 16'h1234);
    chk("c_addr1", c_addr, 4'hE);
    chk("c_valid1", c_valid, 1);
    send(8'h56); send(8'h78);
    chk("c_word2", c_word, 16'h5678);
    chk("c_addr2", c_addr, 4'h0);
    chk("c_ovr", c_ovr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
